// File: rtl/fp_pkg.sv
// Shared floating-point helpers for the arithmetic datapath blocks.
// Holds field-position and width helpers, the exception flag layout, and the
// exponent bias derivation so every fp_* block slices operands identically.
package fp_pkg;

    // Exception flag bit positions within the 3-bit flag vector.
    localparam int FLAG_W    = 3;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_ZERO = 0;

    // Exponent bias for a given exponent width: 2^(exp_w-1) - 1.
    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Total packed width {sign, exp, man}.
    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Bit index of the exponent field LSB within a packed operand.
    function automatic int fp_exp_lsb(input int man_w);
        return man_w;
    endfunction

    // Bit index of the sign bit within a packed operand.
    function automatic int fp_sign_pos(input int exp_w, input int man_w);
        return exp_w + man_w;
    endfunction

    // Width of the full significand product {1,manA}*{1,manB}.
    function automatic int fp_prod_w(input int man_w);
        return 2 * man_w + 2;
    endfunction

    // Width of the signed working exponent; two guard bits cover the
    // full range of eA+eB-BIAS plus the normalise and rounding increments.
    function automatic int fp_sexp_w(input int exp_w);
        return exp_w + 2;
    endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Purpose: normalise the significand product, round to nearest even, then
//          select zero / underflow / saturate / normal result and flags.
// Ports:   sign_i, zero_i, exp_i (signed working exponent e0), prod_i in;
//          result_o {sign,exp,man} and flags_o {ovf,unf,zero} out. Purely combinational.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                     sign_i,
    input  logic                     zero_i,
    input  logic [EXP_W+1:0]         exp_i,
    input  logic [2*MAN_W+1:0]       prod_i,
    output logic [EXP_W+MAN_W:0]     result_o,
    output logic [FLAG_W-1:0]        flags_o
);

    localparam int XW = fp_sexp_w(EXP_W);
    localparam int PW = fp_prod_w(MAN_W);

    logic             msb;
    logic [PW-2:0]    norm;
    logic [MAN_W-1:0] man;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic [MAN_W:0]   man_sum;
    logic             carry;
    logic [MAN_W-1:0] man_rnd;
    logic [XW-1:0]    e1;
    logic [XW-1:0]    e2;
    logic             underflow;
    logic             overflow;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4): the top bit tells
        // whether one extra integer bit must be absorbed into the exponent.
        // Shifting the low case left by one aligns both cases so the
        // mantissa, guard and sticky fields sit at fixed positions.
        msb  = prod_i[PW-1];
        norm = msb ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};

        man      = norm[PW-2 -: MAN_W];
        guard    = norm[MAN_W];
        sticky   = |norm[MAN_W-1:0];
        round_up = guard & (sticky | man[0]);

        // On carry-out the low MAN_W bits of the sum are already zero, which
        // is exactly the rounded mantissa after the exponent bump.
        man_sum = {1'b0, man} + {{MAN_W{1'b0}}, round_up};
        carry   = man_sum[MAN_W];
        man_rnd = man_sum[MAN_W-1:0];

        e1 = exp_i + {{(XW-1){1'b0}}, msb};
        e2 = e1 + {{(XW-1){1'b0}}, carry};

        // e2 is signed: negative or zero underflows; any value with bit
        // EXP_W set (and non-negative) exceeds the all-ones exponent.
        underflow = e2[XW-1] | (e2 == '0);
        overflow  = ~e2[XW-1] & e2[XW-2];

        result_o = '0;
        flags_o  = '0;
        if (zero_i) begin
            flags_o[FLAG_ZERO] = 1'b1;
        end else if (underflow) begin
            flags_o[FLAG_UNF] = 1'b1;
        end else if (overflow) begin
            result_o          = {sign_i, {(EXP_W+MAN_W){1'b1}}};
            flags_o[FLAG_OVF] = 1'b1;
        end else begin
            result_o = {sign_i, e2[EXP_W-1:0], man_rnd};
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Purpose: parametrised 3-stage floating-point multiplier (RNE, flush-to-zero,
//          saturating, no inf/NaN) with valid/ready handshake and exception flags.
// Ports:   clk_i, rst_n_i (sync, active-low); valid_i/ready_o/data_1_i/data_2_i in;
//          valid_o/ready_i/data_mult_o/flags_o out. A full-pipe stall freezes all stages.
// Legal parameter range: EXP_W 4..8, MAN_W 3..23.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [EXP_W+MAN_W:0] data_1_i,
    input  logic [EXP_W+MAN_W:0] data_2_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [EXP_W+MAN_W:0] data_mult_o,
    output logic [FLAG_W-1:0]    flags_o
);

    localparam int BIAS     = fp_bias(EXP_W);
    localparam int XW       = fp_sexp_w(EXP_W);
    localparam int PW       = fp_prod_w(MAN_W);
    localparam int EXP_LSB  = fp_exp_lsb(MAN_W);
    localparam int SIGN_POS = fp_sign_pos(EXP_W, MAN_W);

    localparam logic [XW-1:0] BIAS_X = BIAS[XW-1:0];

    // Global advance enable: the whole pipe moves only when the output
    // register is empty or being drained this cycle.
    logic en;

    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;

    // S1: unpacked operands, sign, unbiased exponent sum, zero detect.
    logic             s1_vld_d,   s1_vld_q;
    logic             s1_sign_d,  s1_sign_q;
    logic             s1_zero_d,  s1_zero_q;
    logic [XW-1:0]    s1_exp_d,   s1_exp_q;
    logic [MAN_W-1:0] s1_man_a_d, s1_man_a_q;
    logic [MAN_W-1:0] s1_man_b_d, s1_man_b_q;

    // S2: full significand product.
    logic             s2_vld_d,   s2_vld_q;
    logic             s2_sign_d,  s2_sign_q;
    logic             s2_zero_d,  s2_zero_q;
    logic [XW-1:0]    s2_exp_d,   s2_exp_q;
    logic [PW-1:0]    s2_prod_d,  s2_prod_q;
    logic [PW-1:0]    mul_a;
    logic [PW-1:0]    mul_b;

    // S3: registered outputs.
    logic                 out_vld_d,   out_vld_q;
    logic [EXP_W+MAN_W:0] out_dat_d,   out_dat_q;
    logic [FLAG_W-1:0]    out_flags_d, out_flags_q;

    logic [EXP_W+MAN_W:0] nr_result;
    logic [FLAG_W-1:0]    nr_flags;

    fp_norm_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm_round (
        .sign_i   (s2_sign_q),
        .zero_i   (s2_zero_q),
        .exp_i    (s2_exp_q),
        .prod_i   (s2_prod_q),
        .result_o (nr_result),
        .flags_o  (nr_flags)
    );

    always_comb begin
        en = ~out_vld_q | ready_i;

        exp_a = data_1_i[EXP_LSB +: EXP_W];
        exp_b = data_2_i[EXP_LSB +: EXP_W];

        // Hidden bit restored; operands zero-extended to product width so the
        // multiply is evaluated at full precision.
        mul_a = {{(MAN_W+1){1'b0}}, 1'b1, s1_man_a_q};
        mul_b = {{(MAN_W+1){1'b0}}, 1'b1, s1_man_b_q};

        // Default: every stage holds.
        s1_vld_d    = s1_vld_q;
        s1_sign_d   = s1_sign_q;
        s1_zero_d   = s1_zero_q;
        s1_exp_d    = s1_exp_q;
        s1_man_a_d  = s1_man_a_q;
        s1_man_b_d  = s1_man_b_q;
        s2_vld_d    = s2_vld_q;
        s2_sign_d   = s2_sign_q;
        s2_zero_d   = s2_zero_q;
        s2_exp_d    = s2_exp_q;
        s2_prod_d   = s2_prod_q;
        out_vld_d   = out_vld_q;
        out_dat_d   = out_dat_q;
        out_flags_d = out_flags_q;

        if (en) begin
            // Bubbles shift like real entries; their payload is don't-care
            // because it is always qualified by the stage valid bit.
            s1_vld_d   = valid_i;
            s1_sign_d  = data_1_i[SIGN_POS] ^ data_2_i[SIGN_POS];
            s1_zero_d  = (exp_a == '0) | (exp_b == '0);
            s1_exp_d   = {2'b00, exp_a} + {2'b00, exp_b} - BIAS_X;
            s1_man_a_d = data_1_i[MAN_W-1:0];
            s1_man_b_d = data_2_i[MAN_W-1:0];

            s2_vld_d   = s1_vld_q;
            s2_sign_d  = s1_sign_q;
            s2_zero_d  = s1_zero_q;
            s2_exp_d   = s1_exp_q;
            s2_prod_d  = mul_a * mul_b;

            out_vld_d   = s2_vld_q;
            out_dat_d   = nr_result;
            out_flags_d = nr_flags;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_vld_q    <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_man_a_q  <= '0;
            s1_man_b_q  <= '0;
            s2_vld_q    <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
            out_flags_q <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_exp_q    <= s1_exp_d;
            s1_man_a_q  <= s1_man_a_d;
            s1_man_b_q  <= s1_man_b_d;
            s2_vld_q    <= s2_vld_d;
            s2_sign_q   <= s2_sign_d;
            s2_zero_q   <= s2_zero_d;
            s2_exp_q    <= s2_exp_d;
            s2_prod_q   <= s2_prod_d;
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign ready_o     = en;
    assign valid_o     = out_vld_q;
    assign data_mult_o = out_dat_q;
    assign flags_o     = out_flags_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Purpose: directed self-checking bench for fp_mult_pipe in half and single precision.
// Latency: checks 3-register latency, back-to-back throughput, RNE ties, boundaries.
// Backpressure: mid-stream ready_i stall and mid-stream reset are exercised.
module tb_fp_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Half-precision instance (defaults).
    logic        h_vld_i, h_rdy_o, h_vld_o, h_rdy_i;
    logic [15:0] h_a, h_b, h_p;
    logic [2:0]  h_flags;

    // Single-precision instance.
    logic        s_vld_i, s_rdy_o, s_vld_o, s_rdy_i;
    logic [31:0] s_a, s_b, s_p;
    logic [2:0]  s_flags;

    fp_mult_pipe u_dut_h (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .valid_i     (h_vld_i),
        .ready_o     (h_rdy_o),
        .data_1_i    (h_a),
        .data_2_i    (h_b),
        .valid_o     (h_vld_o),
        .ready_i     (h_rdy_i),
        .data_mult_o (h_p),
        .flags_o     (h_flags)
    );

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) u_dut_s (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .valid_i     (s_vld_i),
        .ready_o     (s_rdy_o),
        .data_1_i    (s_a),
        .data_2_i    (s_b),
        .valid_o     (s_vld_o),
        .ready_i     (s_rdy_i),
        .data_mult_o (s_p),
        .flags_o     (s_flags)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [18:0] h_q [$];
    int          h_t [$];
    logic [34:0] s_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed output transfer, sampled mid-cycle.
    always @(negedge clk) begin
        if (h_vld_o === 1'b1 && h_rdy_i === 1'b1) begin
            h_q.push_back({h_flags, h_p});
            h_t.push_back(cyc);
        end
        if (s_vld_o === 1'b1 && s_rdy_i === 1'b1)
            s_q.push_back({s_flags, s_p});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send_h(input logic [15:0] a, input logic [15:0] b);
        logic r;
        int   n;
        n = 0;
        h_vld_i = 1'b1; h_a = a; h_b = b;
        do begin
            @(negedge clk); r = h_rdy_o;
            @(posedge clk); #1; n++;
        end while (!r && n < 50);
        check("send_h_accept", r, 1);
        h_vld_i = 1'b0;
    endtask

    task automatic send_s(input logic [31:0] a, input logic [31:0] b);
        logic r;
        int   n;
        n = 0;
        s_vld_i = 1'b1; s_a = a; s_b = b;
        do begin
            @(negedge clk); r = s_rdy_o;
            @(posedge clk); #1; n++;
        end while (!r && n < 50);
        check("send_s_accept", r, 1);
        s_vld_i = 1'b0;
    endtask

    task automatic wait_h(input int n);
        int c;
        c = 0;
        while (h_q.size() < n && c < 40) begin @(posedge clk); #1; c++; end
        check("drain_h", h_q.size(), n);
    endtask

    task automatic wait_s(input int n);
        int c;
        c = 0;
        while (s_q.size() < n && c < 40) begin @(posedge clk); #1; c++; end
        check("drain_s", s_q.size(), n);
    endtask

    // Half-precision stream: {a, b, expected {flags, product}}.
    logic [15:0] hv_a [11] = '{16'h3E00, 16'hC000, 16'h3C01, 16'h3C01, 16'h7BFF, 16'h0400,
                               16'h0000, 16'h4000, 16'h4200, 16'h3800, 16'hBC00};
    logic [15:0] hv_b [11] = '{16'h4000, 16'h3800, 16'h3E00, 16'h3C01, 16'h7BFF, 16'h0400,
                               16'hC500, 16'h4000, 16'h4200, 16'h3800, 16'hBC00};
    logic [18:0] hv_e [11] = '{{3'b000, 16'h4200}, {3'b000, 16'hBC00}, {3'b000, 16'h3E02},
                               {3'b000, 16'h3C02}, {3'b100, 16'h7FFF}, {3'b010, 16'h0000},
                               {3'b001, 16'h0000}, {3'b000, 16'h4400}, {3'b000, 16'h4880},
                               {3'b000, 16'h3400}, {3'b000, 16'h3C00}};

    // Backpressure stream.
    logic [15:0] bp_a [8] = '{16'h4000, 16'h4200, 16'hC400, 16'h3800,
                              16'h4500, 16'h4100, 16'hBC00, 16'h5640};
    logic [15:0] bp_b [8] = '{16'h4000, 16'h4200, 16'h4000, 16'h3800,
                              16'h3C00, 16'h4100, 16'hBC00, 16'h3400};
    logic [15:0] bp_e [8] = '{16'h4400, 16'h4880, 16'hC800, 16'h3400,
                              16'h4500, 16'h4640, 16'h3C00, 16'h4E40};

    // Single-precision stream.
    logic [31:0] sv_a [10] = '{32'h3F800000, 32'h3FC00000, 32'hC0000000, 32'h3F800001,
                               32'h3F800001, 32'h40490FDB, 32'h41200000, 32'h7F7FFFFF,
                               32'h00800000, 32'h00000000};
    logic [31:0] sv_b [10] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3FC00000,
                               32'h3F800001, 32'h40000000, 32'h41200000, 32'h7F7FFFFF,
                               32'h00800000, 32'hC0A00000};
    logic [34:0] sv_e [10] = '{{3'b000, 32'h3F800000}, {3'b000, 32'h40400000},
                               {3'b000, 32'hBF800000}, {3'b000, 32'h3FC00002},
                               {3'b000, 32'h3F800002}, {3'b000, 32'h40C90FDB},
                               {3'b000, 32'h42C80000}, {3'b100, 32'h7FFFFFFF},
                               {3'b010, 32'h00000000}, {3'b001, 32'h00000000}};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [19:0] held;

        rst_n   = 1'b0;
        h_vld_i = 1'b0; h_rdy_i = 1'b1; h_a = '0; h_b = '0;
        s_vld_i = 1'b0; s_rdy_i = 1'b1; s_a = '0; s_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_o", h_vld_o, 0);
        check("rst_data",    h_p, 0);
        check("rst_flags",   h_flags, 0);
        check("rst_ready_o", h_rdy_o, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: count edges from the accepting edge (inclusive) until
        // valid_o is seen high; three register stages give 3.
        h_vld_i = 1'b1; h_a = 16'h3C00; h_b = 16'h3C00;
        @(posedge clk); #1;
        h_vld_i = 1'b0;
        lat = 1;
        while (h_vld_o !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
        check("latency",   lat, 3);
        check("one_data",  h_p, 16'h3C00);
        check("one_flags", h_flags, 3'b000);
        wait_h(1);
        h_q.delete(); h_t.delete();

        // Back-to-back directed vectors including RNE ties and boundaries.
        for (int i = 0; i < 11; i++) send_h(hv_a[i], hv_b[i]);
        wait_h(11);
        for (int i = 0; i < 11; i++) begin
            if (h_q.size() > 0) check($sformatf("h_vec%0d", i), h_q.pop_front(), hv_e[i]);
        end
        check("b2b_consecutive", h_t[1] - h_t[0], 1);
        h_q.delete(); h_t.delete();

        // Backpressure: 5-cycle stall mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) send_h(bp_a[i], bp_b[i]);
            end
            begin
                repeat (5) @(posedge clk);
                #1 h_rdy_i = 1'b0;
                @(negedge clk);
                held = {h_vld_o, h_flags, h_p};
                check("bp_valid_held", h_vld_o, 1);
                check("bp_ready_low",  h_rdy_o, 0);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check($sformatf("bp_stable%0d", k), {h_vld_o, h_flags, h_p}, held);
                    check($sformatf("bp_ready%0d", k), h_rdy_o, 0);
                end
                @(posedge clk); #1 h_rdy_i = 1'b1;
            end
        join
        wait_h(8);
        for (int i = 0; i < 8; i++) begin
            if (h_q.size() > 0) check($sformatf("bp_res%0d", i), h_q.pop_front(), {3'b000, bp_e[i]});
        end
        h_q.delete(); h_t.delete();

        // Reset with three operations in flight, none transferred.
        h_rdy_i = 1'b0;
        send_h(16'h4000, 16'h4000);
        send_h(16'h4200, 16'h4200);
        send_h(16'h4500, 16'h3C00);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid_o", h_vld_o, 0);
        check("mid_rst_data",    h_p, 0);
        check("mid_rst_flags",   h_flags, 0);
        check("mid_rst_ready_o", h_rdy_o, 1);
        rst_n   = 1'b1;
        h_rdy_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("mid_rst_no_emit", h_q.size(), 0);
        send_h(16'h4100, 16'h4100);
        wait_h(1);
        if (h_q.size() > 0) check("post_rst_res", h_q.pop_front(), {3'b000, 16'h4640});

        // Single precision.
        for (int i = 0; i < 10; i++) send_s(sv_a[i], sv_b[i]);
        wait_s(10);
        for (int i = 0; i < 10; i++) begin
            if (s_q.size() > 0) check($sformatf("s_vec%0d", i), s_q.pop_front(), sv_e[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
